// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI serial-flash responder: opcodes, FSM states, status bits.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;

  localparam int ST_WIP = 0;
  localparam int ST_WEL = 1;
  localparam int ST_WP  = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR_RD,
    S_ADDR_WR,
    S_READ_DATA,
    S_WRITE_DATA,
    S_STATUS,
    S_IGNORE
  } state_t;

  function automatic logic [7:0] status_byte(input logic wp, input logic wel);
    logic [7:0] s;
    s         = 8'h00;
    s[ST_WP]  = wp;
    s[ST_WEL] = wel;
    s[ST_WIP] = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/spi_target_shifter.sv
// SPI mode-0 bit engine: synchronisers, sclk/cs_n edge detection, byte assembly and
// MSB-first output shifting. Byte boundaries are reported as a one-clk byte_done pulse.
module spi_target_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic       selected,
  output logic       cs_rise,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       miso
);

  localparam int N = SYNC_STAGES;

  logic [N-1:0] sclk_s, cs_s, mosi_s;
  logic [2:0]   bit_cnt;
  logic [6:0]   rx_shift;
  logic [7:0]   tx_shift;
  logic         sclk_rise, sclk_fall;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_s <= '0;
      cs_s   <= '1;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[N-2:0], sclk};
      cs_s   <= {cs_s[N-2:0], cs_n};
      mosi_s <= {mosi_s[N-2:0], mosi};
    end
  end

  // Index N-2 is the newer of the last two stages.
  assign sclk_rise = sclk_s[N-2] & ~sclk_s[N-1];
  assign sclk_fall = ~sclk_s[N-2] & sclk_s[N-1];
  assign cs_rise   = cs_s[N-2] & ~cs_s[N-1];
  assign selected  = ~cs_s[N-1];
  assign miso      = tx_shift[7];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      byte_done <= 1'b0;
      rx_byte   <= '0;
    end else begin
      byte_done <= 1'b0;
      if (!selected || cs_rise) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
      end else begin
        if (sclk_rise) begin
          rx_shift <= {rx_shift[5:0], mosi_s[N-2]};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_done <= 1'b1;
            rx_byte   <= {rx_shift, mosi_s[N-2]};
          end
        end
        // The fall that closes a byte (count back at 0) must not disturb a freshly loaded byte.
        if (tx_load)
          tx_shift <= tx_byte;
        else if (sclk_fall && bit_cnt != 3'd0)
          tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_flash_target.sv
// Serial-flash responder (READ/WRITE/RDSR/WREN/WRDI) over a register-backed byte array.
// Optional write-protect pin enabled by defining SPI_FLASH_WP_EN.
module spi_flash_target
  import spi_flash_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] INIT_BYTE   = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
`ifdef SPI_FLASH_WP_EN
  input  logic              wp_n,
`endif
  output logic              miso,
  output logic              miso_oe,
  output logic              selected,
  output logic              cmd_valid,
  output logic [7:0]        cmd_op,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0]        mem [DEPTH];
  state_t            state;
  logic              wel, wp_active;
  logic [ADDR_W-1:0] addr, next_addr, rx_addr;
  logic              cs_rise, byte_done, tx_load;
  logic [7:0]        rx_byte, tx_byte;

  spi_target_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .tx_load   (tx_load),
    .tx_byte   (tx_byte),
    .selected  (selected),
    .cs_rise   (cs_rise),
    .byte_done (byte_done),
    .rx_byte   (rx_byte),
    .miso      (miso)
  );

`ifdef SPI_FLASH_WP_EN
  logic [SYNC_STAGES-1:0] wp_s;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wp_s <= '1;
    else        wp_s <= {wp_s[SYNC_STAGES-2:0], wp_n};
  end
  assign wp_active = ~wp_s[SYNC_STAGES-1];
`else
  assign wp_active = 1'b0;
`endif

  assign miso_oe   = selected;
  assign cmd_valid = byte_done && (state == S_CMD);
  assign next_addr = addr + ADDR_W'(1);
  assign rx_addr   = rx_byte[ADDR_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      wel     <= 1'b0;
      addr    <= '0;
      cmd_op  <= '0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      tx_load <= 1'b0;
      tx_byte <= '0;
      // NOTE: the array must return to the erased state on reset, so it is built from
      // resettable flops rather than a RAM macro without reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_BYTE;
    end else begin
      wr_stb  <= 1'b0;
      tx_load <= 1'b0;
      if (state == S_IDLE && selected && !cs_rise) state <= S_CMD;

      if (byte_done) begin
        tx_load <= 1'b1;
        tx_byte <= 8'h00;
        unique case (state)
          S_CMD: begin
            cmd_op <= rx_byte;
            case (rx_byte)
              OP_READ:  state <= S_ADDR_RD;
              OP_WRITE: state <= S_ADDR_WR;
              OP_RDSR: begin
                state   <= S_STATUS;
                tx_byte <= status_byte(wp_active, wel);
              end
              OP_WREN: begin
                if (!wp_active) wel <= 1'b1;
                state <= S_IGNORE;
              end
              OP_WRDI: begin
                wel   <= 1'b0;
                state <= S_IGNORE;
              end
              default: state <= S_IGNORE;
            endcase
          end
          S_ADDR_RD: begin
            addr    <= rx_addr;
            tx_byte <= mem[rx_addr];
            state   <= S_READ_DATA;
          end
          S_ADDR_WR: begin
            addr  <= rx_addr;
            state <= S_WRITE_DATA;
          end
          S_READ_DATA: begin
            addr    <= next_addr;
            tx_byte <= mem[next_addr];
          end
          S_WRITE_DATA: begin
            if (wel && !wp_active) begin
              mem[addr] <= rx_byte;
              wr_stb    <= 1'b1;
              wr_addr   <= addr;
              wr_data   <= rx_byte;
            end
            addr <= next_addr;
          end
          S_STATUS: tx_byte <= status_byte(wp_active, wel);
          default: ;
        endcase
      end

      // Deselect wins over any transition above but only after the completing byte is processed.
      if (cs_rise) begin
        state   <= S_IDLE;
        tx_load <= 1'b0;
        if (state == S_ADDR_WR || state == S_WRITE_DATA) wel <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_target.sv
// Directed bench for spi_flash_target: drives SPI mode-0 transactions and checks
// write strobes, read data, status bytes and reset behaviour against hand-computed values.
module tb_spi_flash_target;
  import spi_flash_pkg::*;

  logic       clk = 1'b0;
  logic       reset, sclk, cs_n, mosi;
  logic       miso, miso_oe, selected, cmd_valid, wr_stb;
  logic [7:0] cmd_op, wr_addr, wr_data;
`ifdef SPI_FLASH_WP_EN
  logic       wp_n = 1'b1;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cmd_count = 0;
  logic [7:0] wr_log_a[$];
  logic [7:0] wr_log_d[$];
  logic [7:0] rd_buf[4];

  spi_flash_target dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
`ifdef SPI_FLASH_WP_EN
    .wp_n      (wp_n),
`endif
    .miso      (miso),
    .miso_oe   (miso_oe),
    .selected  (selected),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb) begin
      wr_log_a.push_back(wr_addr);
      wr_log_d.push_back(wr_data);
    end
    if (cmd_valid) cmd_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sclk period = 160 ns (16 system clocks); bits MSB first, miso captured on the rising edge.
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, input int nbits);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      #40 sclk = 1'b1;
      rx[i] = miso;
      #80 sclk = 1'b0;
      #40;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] r;
    xfer(b, r, 8);
  endtask

  task automatic begin_txn();
    @(negedge clk);
    cs_n = 1'b0;
    #80;
  endtask

  task automatic end_txn();
    #40 cs_n = 1'b1;
    #200;
  endtask

  task automatic cmd_only(input logic [7:0] op);
    begin_txn();
    send(op);
    end_txn();
  endtask

  task automatic read_mem(input logic [7:0] a, input int n);
    logic [7:0] r;
    begin_txn();
    send(OP_READ);
    send(a);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, r, 8);
      rd_buf[i] = r;
    end
    end_txn();
  endtask

  task automatic rdsr(input int n);
    logic [7:0] r;
    begin_txn();
    send(OP_RDSR);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, r, 8);
      rd_buf[i] = r;
    end
    end_txn();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    reset = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    #23;
    check("rst_miso",     miso,      0);
    check("rst_miso_oe",  miso_oe,   0);
    check("rst_selected", selected,  0);
    check("rst_cmd_vld",  cmd_valid, 0);
    check("rst_cmd_op",   cmd_op,    0);
    check("rst_wr_stb",   wr_stb,    0);
    check("rst_wr_addr",  wr_addr,   0);
    check("rst_wr_data",  wr_data,   0);
    @(negedge clk) reset = 1'b1;
    #100;

    // WREN then status shows WEL=1 on three consecutive bytes.
    cmd_only(OP_WREN);
    check("wren_cmd_op", cmd_op, 8'h06);
    check("wren_cmd_cnt", cmd_count, 1);
    begin_txn();
    check("sel_active", selected, 1);
    check("oe_active",  miso_oe,  1);
    send(OP_RDSR);
    for (int i = 0; i < 3; i++) begin
      xfer(8'h00, r, 8);
      check($sformatf("rdsr_wel_%0d", i), r, 8'h02);
    end
    end_txn();
    check("sel_idle", selected, 0);

    // WRITE 0x10: A5, 5A.
    begin_txn();
    send(OP_WRITE); send(8'h10); send(8'hA5); send(8'h5A);
    end_txn();
    check("wr_count_1", wr_log_a.size(), 2);
    check("wr0_addr", wr_log_a[0], 8'h10);
    check("wr0_data", wr_log_d[0], 8'hA5);
    check("wr1_addr", wr_log_a[1], 8'h11);
    check("wr1_data", wr_log_d[1], 8'h5A);
    check("wr_cmd_op", cmd_op, 8'h02);
    rdsr(1);
    check("rdsr_after_wr", rd_buf[0], 8'h00);
    read_mem(8'h10, 2);
    check("rd_10", rd_buf[0], 8'hA5);
    check("rd_11", rd_buf[1], 8'h5A);
    check("rd_cmd_op", cmd_op, 8'h03);

    // WRITE without WREN is dropped.
    begin_txn();
    send(OP_WRITE); send(8'h20); send(8'h33);
    end_txn();
    check("nowel_count", wr_log_a.size(), 2);
    read_mem(8'h20, 1);
    check("rd_20_erased", rd_buf[0], 8'hFF);

    // Wrap from 0xFF to 0x00.
    cmd_only(OP_WREN);
    begin_txn();
    send(OP_WRITE); send(8'h00); send(8'h11);
    end_txn();
    check("wr00_count", wr_log_a.size(), 3);
    check("wr00_addr", wr_log_a[2], 8'h00);
    check("wr00_data", wr_log_d[2], 8'h11);
    read_mem(8'hFF, 2);
    check("wrap_ff", rd_buf[0], 8'hFF);
    check("wrap_00", rd_buf[1], 8'h11);

    // Unknown opcode: miso stays low.
    begin_txn();
    send(8'h9F);
    xfer(8'hAA, r, 8);
    check("ignore_miso", r, 8'h00);
    end_txn();
    check("ignore_cmd_op", cmd_op, 8'h9F);

    // Partial data byte aborted by deselect.
    cmd_only(OP_WREN);
    begin_txn();
    send(OP_WRITE); send(8'h30);
    xfer(8'hC3, r, 5);
    end_txn();
    check("abort_count", wr_log_a.size(), 3);
    check("abort_sel",   selected, 0);
    check("abort_miso",  miso, 0);
    read_mem(8'h30, 1);
    check("abort_rd_30", rd_buf[0], 8'hFF);
    rdsr(1);
    check("abort_wel_clr", rd_buf[0], 8'h00);
    cmd_only(OP_WREN);
    begin_txn();
    send(OP_WRITE); send(8'h30); send(8'hC3);
    end_txn();
    check("after_abort_count", wr_log_a.size(), 4);
    read_mem(8'h30, 1);
    check("after_abort_rd", rd_buf[0], 8'hC3);

    // WRDI clears WEL.
    cmd_only(OP_WREN);
    cmd_only(OP_WRDI);
    rdsr(1);
    check("wrdi_status", rd_buf[0], 8'h00);

`ifdef SPI_FLASH_WP_EN
    wp_n = 1'b0;
    #100;
    cmd_only(OP_WREN);
    begin_txn();
    send(OP_WRITE); send(8'h05); send(8'h77);
    end_txn();
    check("wp_count", wr_log_a.size(), 4);
    rdsr(1);
    check("wp_status", rd_buf[0], 8'h80);
    read_mem(8'h05, 1);
    check("wp_rd_05", rd_buf[0], 8'hFF);
    wp_n = 1'b1;
    #100;
`endif

    // Async reset mid-write re-erases the array and clears WEL.
    cmd_only(OP_WREN);
    begin_txn();
    send(OP_WRITE); send(8'h40);
    xfer(8'h5C, r, 5);
    reset = 1'b0;
    #30;
    check("midrst_sel",    selected, 0);
    check("midrst_cmd_op", cmd_op,   0);
    cs_n = 1'b1;
    #20 reset = 1'b1;
    #200;
    read_mem(8'h10, 1);
    check("midrst_rd_10", rd_buf[0], 8'hFF);
    rdsr(1);
    check("midrst_status", rd_buf[0], 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
